// File: rtl/rvfpm_pkg.sv
// Shared decode constants, payload types and the RV32F decode helper for the rvfpm issue path.
package rvfpm_pkg;

   localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
   localparam logic [6:0] OPC_FMADD    = 7'b1000011;
   localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
   localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
   localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
   localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
   localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

   localparam logic [4:0] F5_CMP      = 5'b10100;
   localparam logic [4:0] F5_FCVT_W_S = 5'b11000;
   localparam logic [4:0] F5_FMV_X_W  = 5'b11100;
   localparam logic [4:0] F5_FCVT_S_W = 5'b11010;
   localparam logic [4:0] F5_FMV_W_X  = 5'b11110;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } flags_t;

   typedef struct packed {
      logic       valid;
      logic       is_x;
      logic [4:0] fd;
      logic [4:0] rd;
   } inflight_t;

   typedef struct packed {
      logic valid;
      logic uses_rs1;
      logic uses_rs2;
      logic uses_rs3;
      logic writes_fd;
      logic writes_x;
   } decode_t;

   // Unsupported opcodes decode to all-zero: accepted by the handshake, never issued.
   function automatic decode_t decode_fp_instr(input logic [31:0] instr);
      decode_t    d;
      logic [4:0] f5;
      d  = '0;
      f5 = instr[31:27];
      case (instr[6:0])
         OPC_OP_FP: begin
            d.valid     = 1'b1;
            d.writes_x  = (f5 == F5_CMP) || (f5 == F5_FCVT_W_S) || (f5 == F5_FMV_X_W);
            d.writes_fd = !d.writes_x;
            d.uses_rs1  = !((f5 == F5_FCVT_S_W) || (f5 == F5_FMV_W_X));
            d.uses_rs2  = 1'b1;
         end
         OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
            d.valid     = 1'b1;
            d.uses_rs1  = 1'b1;
            d.uses_rs2  = 1'b1;
            d.uses_rs3  = 1'b1;
            d.writes_fd = 1'b1;
         end
         OPC_LOAD_FP: begin
            d.valid     = 1'b1;
            d.writes_fd = 1'b1;
         end
         OPC_STORE_FP: begin
            d.valid    = 1'b1;
            d.uses_rs2 = 1'b1;
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/rvfpm_result_fifo.sv
// Synchronous FIFO with occupancy count; simultaneous push and pop allowed even when full.
module rvfpm_result_fifo #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               pop_data,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule

// File: rtl/rvfpm_issue_ctrl.sv
// Issue controller for the rvfpm FPU: scoreboarded dispatch, fixed-latency result tracking,
// credit-protected X-register writeback and sticky fflags.
module rvfpm_issue_ctrl
   import rvfpm_pkg::*;
#(
   parameter int unsigned PIPELINE_STAGES = 4,
   parameter int unsigned NUM_REGS        = 32,
   parameter int unsigned RESULT_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_xdata,
   output logic        fpu_valid,
   output logic [31:0] fpu_instr,
   output logic [31:0] fpu_xdata,
   input  logic        fpu_res_valid,
   input  logic [31:0] fpu_res_data,
   input  logic [4:0]  fpu_res_flags,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [4:0]  fflags,
   input  logic        fflags_clr,
   output logic        busy,
   output logic        proto_err
);

   localparam int unsigned CW = $clog2(RESULT_DEPTH + 1);
   localparam int unsigned FW = 37;

   decode_t             dec_c;
   inflight_t           iss_q;
   inflight_t           pipe_q [PIPELINE_STAGES];
   inflight_t           tail_c;
   logic [NUM_REGS-1:0] sb_q, sb_set_c, sb_clr_c, sb_eff_c;
   logic [CW-1:0]       inflight_x_q, fifo_count;
   logic [CW:0]         credit_used_c;
   flags_t              fflags_q;
   logic                hazard_c, credit_stall_c, accept_c, issue_c, push_c, pipe_any_c;
   logic                fifo_empty;
   logic [FW-1:0]       fifo_head;

   // Decode, hazard and credit checks; a retiring fd is bypassed so its dependant issues that cycle.
   always_comb begin
      dec_c    = decode_fp_instr(in_instr);
      tail_c   = pipe_q[PIPELINE_STAGES-1];
      sb_clr_c = '0;
      if (tail_c.valid && !tail_c.is_x) sb_clr_c[tail_c.fd] = 1'b1;
      sb_eff_c = sb_q & ~sb_clr_c;
      hazard_c = (dec_c.uses_rs1  && sb_eff_c[in_instr[19:15]]) ||
                 (dec_c.uses_rs2  && sb_eff_c[in_instr[24:20]]) ||
                 (dec_c.uses_rs3  && sb_eff_c[in_instr[31:27]]) ||
                 (dec_c.writes_fd && sb_eff_c[in_instr[11:7]]);
      credit_used_c  = (CW+1)'(inflight_x_q) + (CW+1)'(fifo_count);
      credit_stall_c = dec_c.writes_x && (credit_used_c >= (CW+1)'(RESULT_DEPTH));
      in_ready       = !reset && !hazard_c && !credit_stall_c;
      accept_c       = in_valid && in_ready;
      issue_c        = accept_c && dec_c.valid;
      sb_set_c       = '0;
      if (issue_c && dec_c.writes_fd) sb_set_c[in_instr[11:7]] = 1'b1;
      push_c         = tail_c.valid && tail_c.is_x;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fpu_valid    <= 1'b0;
         fpu_instr    <= '0;
         fpu_xdata    <= '0;
         iss_q        <= '0;
         for (int i = 0; i < int'(PIPELINE_STAGES); i++) pipe_q[i] <= '0;
         sb_q         <= '0;
         inflight_x_q <= '0;
         fflags_q     <= '0;
         proto_err    <= 1'b0;
      end else begin
         fpu_valid <= issue_c;
         if (issue_c) begin
            fpu_instr <= in_instr;
            fpu_xdata <= in_xdata;
         end
         iss_q.valid <= issue_c;
         iss_q.is_x  <= dec_c.writes_x;
         iss_q.fd    <= in_instr[11:7];
         iss_q.rd    <= in_instr[11:7];
         pipe_q[0]   <= iss_q;
         for (int i = 1; i < int'(PIPELINE_STAGES); i++) pipe_q[i] <= pipe_q[i-1];
         sb_q <= sb_eff_c | sb_set_c;
         case ({issue_c && dec_c.writes_x, push_c})
            2'b10:   inflight_x_q <= inflight_x_q + CW'(1);
            2'b01:   inflight_x_q <= inflight_x_q - CW'(1);
            default: ;
         endcase
         // Clear takes effect before new flags are merged in.
         if (tail_c.valid)
            fflags_q <= flags_t'((fflags_clr ? 5'b0 : 5'(fflags_q)) | fpu_res_flags);
         else if (fflags_clr)
            fflags_q <= '0;
         if (fpu_res_valid != tail_c.valid) proto_err <= 1'b1;
      end
   end

   rvfpm_result_fifo #(
      .WIDTH (FW),
      .DEPTH (RESULT_DEPTH)
   ) u_result_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_c),
      .push_data ({tail_c.rd, fpu_res_data}),
      .pop       (wb_valid && wb_ready),
      .pop_data  (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      pipe_any_c = 1'b0;
      for (int i = 0; i < int'(PIPELINE_STAGES); i++) pipe_any_c = pipe_any_c | pipe_q[i].valid;
   end

   assign wb_valid = !fifo_empty;
   assign wb_rd    = fifo_head[36:32];
   assign wb_data  = fifo_head[31:0];
   assign fflags   = 5'(fflags_q);
   assign busy     = iss_q.valid || pipe_any_c || (fifo_count != '0);

endmodule
